// File: rtl/alu_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_driver
// Purpose  : Sequencer in front of a single registered ALU (1-cycle latency).
//            Accepts one multi-word operation on a valid/ready request port.
//            It feeds the ALU one BITS-wide slice per EXEC/CAPT pair and chains
//            carry across slices for add. It reassembles the full-width result
//            and returns it on a valid/ready response port.
// Ports    : clk, rst_n                     clock, async active-low reset
//            req_valid/req_ready            request handshake
//            req_opcode, req_a, req_b       operation and full-width operands
//            req_carry                      carry into slice 0 (add only)
//            alu_in_a/b, alu_opcode,        registered slice drive to the ALU
//            alu_carry_in                   (alu_opcode 0 = ALU idle)
//            alu_sum, alu_carry_out         ALU registered result
//            rsp_valid/rsp_ready            response handshake
//            rsp_result, rsp_carry, rsp_err assembled result, final carry,
//                                           divide-by-zero flag
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_driver #(
  parameter int BITS        = 8,
  parameter int opcode_size = 4,
  parameter int WORDS       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [opcode_size-1:0] req_opcode,
  input  logic [BITS*WORDS-1:0]  req_a,
  input  logic [BITS*WORDS-1:0]  req_b,
  input  logic                   req_carry,
  output logic [BITS-1:0]        alu_in_a,
  output logic [BITS-1:0]        alu_in_b,
  output logic [opcode_size-1:0] alu_opcode,
  output logic                   alu_carry_in,
  input  logic [BITS-1:0]        alu_sum,
  input  logic                   alu_carry_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [BITS*WORDS-1:0]  rsp_result,
  output logic                   rsp_carry,
  output logic                   rsp_err
);

  localparam int W     = BITS * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [opcode_size-1:0] c_op_add    = opcode_size'(1);
  localparam logic [opcode_size-1:0] c_op_div    = opcode_size'(4);
  localparam logic [opcode_size-1:0] c_op_bit_lo = opcode_size'(7);
  localparam logic [opcode_size-1:0] c_op_bit_hi = opcode_size'(12);
  localparam logic [IDX_W-1:0]       c_last_idx  = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // How the accepted operation is walked across the slices.
  typedef enum logic [1:0] {
    M_CHAIN  = 2'd0,  // add: all slices, carry chained LSB to MSB
    M_SLICED = 2'd1,  // bitwise: all slices, independent, no carry
    M_SINGLE = 2'd2,  // everything else: slice 0 only
    M_DIVZ   = 2'd3   // divide by zero: answered locally, no ALU issue
  } mode_t;

  state_t                 state_q,        state_d;
  mode_t                  mode_q,         mode_d;
  logic [W-1:0]           a_q,            a_d;
  logic [W-1:0]           b_q,            b_d;
  logic [IDX_W-1:0]       idx_q,          idx_d;
  logic [W-1:0]           result_q,       result_d;
  logic                   carry_q,        carry_d;
  logic                   err_q,          err_d;
  logic [BITS-1:0]        alu_in_a_q,     alu_in_a_d;
  logic [BITS-1:0]        alu_in_b_q,     alu_in_b_d;
  logic [opcode_size-1:0] alu_opcode_q,   alu_opcode_d;
  logic                   alu_carry_in_q, alu_carry_in_d;

  logic                   w_req_divz;
  mode_t                  w_req_mode;
  logic                   w_last;
  logic [IDX_W-1:0]       w_idx_nxt;

  // Classify the incoming request; only meaningful on the accept cycle.
  always_comb begin
    w_req_divz = (req_opcode == c_op_div) && (req_b[BITS-1:0] == '0);
    if (w_req_divz) begin
      w_req_mode = M_DIVZ;
    end else if (req_opcode == c_op_add) begin
      w_req_mode = M_CHAIN;
    end else if ((req_opcode >= c_op_bit_lo) && (req_opcode <= c_op_bit_hi)) begin
      w_req_mode = M_SLICED;
    end else begin
      w_req_mode = M_SINGLE;
    end
  end

  assign w_last    = (mode_q == M_SINGLE) || (idx_q == c_last_idx);
  assign w_idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    a_d            = a_q;
    b_d            = b_q;
    idx_d          = idx_q;
    result_d       = result_q;
    carry_d        = carry_q;
    err_d          = err_q;
    alu_in_a_d     = alu_in_a_q;
    alu_in_b_d     = alu_in_b_q;
    alu_opcode_d   = alu_opcode_q;
    alu_carry_in_d = alu_carry_in_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mode_d   = w_req_mode;
          a_d      = req_a;
          b_d      = req_b;
          idx_d    = '0;
          result_d = '0;  // upper slices stay zero for single-slice ops
          carry_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = S_EXEC;
          if (w_req_divz) begin
            // The EXEC cycle is spent with the ALU idle; the answer is local.
            alu_in_a_d     = '0;
            alu_in_b_d     = '0;
            alu_opcode_d   = '0;
            alu_carry_in_d = 1'b0;
          end else begin
            alu_in_a_d     = req_a[BITS-1:0];
            alu_in_b_d     = req_b[BITS-1:0];
            alu_opcode_d   = req_opcode;
            alu_carry_in_d = (w_req_mode == M_CHAIN) ? req_carry : 1'b0;
          end
        end
      end

      S_EXEC: begin
        if (mode_q == M_DIVZ) begin
          result_d = '1;
          carry_d  = 1'b0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_CAPT;
        end
      end

      S_CAPT: begin
        result_d[int'(idx_q)*BITS +: BITS] = alu_sum;
        carry_d = (mode_q == M_SLICED) ? 1'b0 : alu_carry_out;
        if (w_last) begin
          alu_in_a_d     = '0;
          alu_in_b_d     = '0;
          alu_opcode_d   = '0;
          alu_carry_in_d = 1'b0;
          state_d        = S_DONE;
        end else begin
          idx_d          = w_idx_nxt;
          alu_in_a_d     = a_q[int'(w_idx_nxt)*BITS +: BITS];
          alu_in_b_d     = b_q[int'(w_idx_nxt)*BITS +: BITS];
          // Opcode register simply holds for the next slice.
          alu_carry_in_d = (mode_q == M_CHAIN) ? alu_carry_out : 1'b0;
          state_d        = S_EXEC;
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mode_q         <= M_SINGLE;
      a_q            <= '0;
      b_q            <= '0;
      idx_q          <= '0;
      result_q       <= '0;
      carry_q        <= 1'b0;
      err_q          <= 1'b0;
      alu_in_a_q     <= '0;
      alu_in_b_q     <= '0;
      alu_opcode_q   <= '0;
      alu_carry_in_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      a_q            <= a_d;
      b_q            <= b_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      carry_q        <= carry_d;
      err_q          <= err_d;
      alu_in_a_q     <= alu_in_a_d;
      alu_in_b_q     <= alu_in_b_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_carry_in_q <= alu_carry_in_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_DONE);
  assign rsp_result   = result_q;
  assign rsp_carry    = carry_q;
  assign rsp_err      = err_q;
  assign alu_in_a     = alu_in_a_q;
  assign alu_in_b     = alu_in_b_q;
  assign alu_opcode   = alu_opcode_q;
  assign alu_carry_in = alu_carry_in_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_driver
// Purpose  : Self-checking bench for alu_seq_driver (BITS=8, WORDS=4). Holds a
//            registered 8-bit ALU model and a full-width reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_driver;

  localparam int BITS  = 8;
  localparam int OPW   = 4;
  localparam int WORDS = 4;
  localparam int W     = BITS * WORDS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [OPW-1:0] req_opcode = '0;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic           req_carry = 1'b0;
  logic [BITS-1:0] alu_in_a, alu_in_b;
  logic [OPW-1:0] alu_opcode;
  logic           alu_carry_in;
  logic [BITS-1:0] alu_sum = '0;
  logic           alu_carry_out = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry;
  logic           rsp_err;

  int checks   = 0;
  int failures = 0;

  alu_seq_driver #(.BITS(BITS), .opcode_size(OPW), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_carry(req_carry),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_carry_in(alu_carry_in), .alu_sum(alu_sum), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // 8-bit ALU behaviour: returns {carry_out, sum}.
  function automatic logic [8:0] alu8(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic cin);
    logic [8:0]  r;
    logic [15:0] p;
    logic [7:0]  s;
    r = '0; p = '0; s = '0;
    case (op)
      4'd1: r = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      4'd2: r = {1'b0, a} - {1'b0, b};
      4'd3: begin p = {8'b0, a} * {8'b0, b}; r = {|p[15:8], p[7:0]}; end
      4'd4: r = (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
      4'd5: r = {a[0], 1'b0, a[7:1]};
      4'd6: r = {a[7], a[6:0], 1'b0};
      4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
        case (op)
          4'd7:    s = a & b;
          4'd8:    s = a | b;
          4'd9:    s = ~(a & b);
          4'd10:   s = a ^ b;
          4'd11:   s = ~(a | b);
          default: s = ~(a ^ b);
        endcase
        r = {^s, s};  // parity on carry_out so a leaked carry is visible
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    {alu_carry_out, alu_sum} <= alu8(alu_opcode, alu_in_a, alu_in_b, alu_carry_in);
  end

  // Every cycle the ALU is driven with a non-zero opcode is logged.
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } iss_t;
  iss_t log_q[$];

  always @(negedge clk) begin
    if (alu_opcode != '0) log_q.push_back('{alu_opcode, alu_in_a, alu_in_b, alu_carry_in});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Full-width reference: whole-operand arithmetic, no slicing.
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output logic [W-1:0] res, output logic rc,
                           output logic re, output int lat);
    logic [W:0] t;
    logic [8:0] r;
    res = '0; rc = 1'b0; re = 1'b0; lat = 2;
    if (op == 4'd1) begin
      t = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      res = t[W-1:0]; rc = t[W]; lat = 2 * WORDS;
    end else if (op >= 4'd7 && op <= 4'd12) begin
      case (op)
        4'd7:    res = a & b;
        4'd8:    res = a | b;
        4'd9:    res = ~(a & b);
        4'd10:   res = a ^ b;
        4'd11:   res = ~(a | b);
        default: res = ~(a ^ b);
      endcase
      lat = 2 * WORDS;
    end else if (op == 4'd4 && b[7:0] == 8'd0) begin
      res = '1; re = 1'b1; lat = 1;
    end else begin
      r = alu8(op, a[7:0], b[7:0], 1'b0);
      res = {{(W-8){1'b0}}, r[7:0]}; rc = r[8];
    end
  endtask

  // Carry entering slice i of a full-width add: carry out of the low i*8 bits.
  function automatic logic exp_cin(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic c, input int i);
    logic [W:0] mask, t;
    if (op != 4'd1) return 1'b0;
    if (i == 0) return c;
    mask = ((W+1)'(1) << (8 * i)) - (W+1)'(1);
    t = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (W+1)'(c);
    return t[8 * i];
  endfunction

  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input int hold,
                        input logic [W-1:0] e_res, input logic e_rc, input logic e_re,
                        input int e_lat);
    int lat;
    int issues;
    issues = (e_lat == 1) ? 0 : e_lat / 2;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_carry = c;
    check({name, " req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    log_q.delete();
    // Junk on the request port while busy must be ignored.
    req_opcode = 4'd3; req_a = $urandom; req_b = $urandom; req_carry = 1'b1;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(e_lat));
    check({name, " result"}, 64'(rsp_result), 64'(e_res));
    check({name, " carry"}, 64'(rsp_carry), 64'(e_rc));
    check({name, " err"}, 64'(rsp_err), 64'(e_re));
    check({name, " alu cycles"}, 64'(log_q.size()), 64'(2 * issues));
    for (int k = 0; k < issues && 2 * k + 1 < log_q.size(); k++) begin
      check({name, " issue op"}, 64'(log_q[2*k].op), 64'(op));
      check({name, " issue a"}, 64'(log_q[2*k].a), 64'(a[8*k +: 8]));
      check({name, " issue b"}, 64'(log_q[2*k].b), 64'(b[8*k +: 8]));
      check({name, " issue cin"}, 64'(log_q[2*k].cin), 64'(exp_cin(op, a, b, c, k)));
      check({name, " issue stable"}, 64'(log_q[2*k+1]), 64'(log_q[2*k]));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({name, " hold valid/ready"}, {62'd0, rsp_valid, req_ready}, 64'd2);
      check({name, " hold result"}, {31'd0, rsp_err, rsp_carry, rsp_result},
            {31'd0, e_re, e_rc, e_res});
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check({name, " after rsp"}, {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       c;
    logic [W-1:0] res;
    logic       rc;
    logic       re;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b, e_res;
    logic         c, e_rc, e_re;
    int           e_lat;
    logic         seen;

    vecs[0] = '{"add_carry_chain", 4'd1,  32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0, 8};
    vecs[1] = '{"add_wrap",        4'd1,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 8};
    vecs[2] = '{"xor",             4'd10, 32'h12345678, 32'hFFFF0000, 1'b0, 32'hEDCB5678, 1'b0, 1'b0, 8};
    vecs[3] = '{"sub",             4'd2,  32'h00000005, 32'h00000007, 1'b0, 32'h000000FE, 1'b1, 1'b0, 2};
    vecs[4] = '{"divz",            4'd4,  32'h00001234, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1};

    // Reset state
    #2;
    check("reset outs", {39'd0, req_ready, rsp_valid, alu_opcode, alu_in_a, alu_in_b,
                         alu_carry_in, rsp_carry, rsp_err}, 64'h1000000);
    check("reset result", 64'(rsp_result), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, i % 3,
             vecs[i].res, vecs[i].rc, vecs[i].re, vecs[i].lat);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(1, 12));
      a  = $urandom;
      b  = $urandom;
      c  = 1'($urandom_range(0, 1));
      if (op == 4'd4 && $urandom_range(0, 2) == 0) b[7:0] = 8'd0;
      if (op == 4'd1 && $urandom_range(0, 3) == 0) a = ~b;  // long carry chains
      ref_model(op, a, b, c, e_res, e_rc, e_re, e_lat);
      run_op("random", op, a, b, c, int'($urandom_range(0, 3)), e_res, e_rc, e_re, e_lat);
    end

    // Response back-pressure for 5 cycles, then reset during EXEC of a new add.
    run_op("hold5", 4'd1, 32'h0000FFFF, 32'h00000001, 1'b0, 5, 32'h00010000, 1'b0, 1'b0, 8);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 4'd1; req_a = 32'h11111111; req_b = 32'h22222222; req_carry = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("exec opcode before reset", 64'(alu_opcode), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midop reset outs", {39'd0, req_ready, rsp_valid, alu_opcode, alu_in_a, alu_in_b,
                               alu_carry_in, rsp_carry, rsp_err}, 64'h1000000);
    check("midop reset result", 64'(rsp_result), 64'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("no rsp after abort", 64'(seen), 64'd0);
    check("ready after abort", 64'(req_ready), 64'd1);

    run_op("post_reset_and", 4'd7, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 0,
           32'hF000F000, 1'b0, 1'b0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
